count_readout: RTL and testbench

//  Sits directly downstream of the pulse counter. Snapshots the count on an

---
 rtl/count_readout_if.sv | 19 +
 rtl/count_readout.sv | 166 ++++++++++++++++
 tb/tb_count_readout.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_readout_if.sv
// Byte-stream link from the count readout to the host-link transmitter.
// The master drives data/valid and the slave drives ready.
interface count_readout_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/count_readout.sv
// Snapshots the pulse counter on a tick or saturation edge, clears it, buffers snapshots and
// streams each one LSB-first as bytes. Optional sequence-number header: READOUT_SEQ_EN.
module count_readout #(
    parameter int unsigned RESOLUTION = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RESOLUTION-1:0] counter_in,
    input  logic                  overflow,
    input  logic                  capture,
    output logic                  clear_out,
    output logic                  lost,
    count_readout_if.master       out_if
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PtrW = AW + 1;
`ifdef READOUT_SEQ_EN
    localparam int unsigned HdrW = 8;
`else
    localparam int unsigned HdrW = 0;
`endif
    localparam int unsigned FrameW = RESOLUTION + HdrW;
    localparam int unsigned NBytes = FrameW / 8;
    localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBytes - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;
    state_e state_q, state_d;

    logic              overflow_q, clear_q, lost_q;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FrameW-1:0] mem_q [DEPTH];
    logic [FrameW-1:0] wr_entry;
    logic [FrameW-1:0] sr_q, sr_d, sr_shift;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              trig, full, empty, push, pop, hs, last;

    assign trig     = capture | (overflow & ~overflow_q);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push     = trig & ~full;
    assign hs       = out_valid_q & out_if.out_ready;
    assign last     = (idx_q == LastIdx);
    assign sr_shift = sr_q >> 8;

`ifdef READOUT_SEQ_EN
    logic [7:0] seq_q;

    // Counts every trigger, dropped or not, so the host can see gaps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seq_q <= '0;
        end else if (trig) begin
            seq_q <= seq_q + 8'd1;
        end
    end

    // Header in the low byte so it leaves the shifter first.
    assign wr_entry = {counter_in, seq_q};
`else
    assign wr_entry = counter_in;
`endif

    // Full is judged on the registered pointers, so a same-cycle pop never frees a slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            clear_q    <= 1'b0;
            lost_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            overflow_q <= overflow;
            clear_q    <= trig;
            if (trig && full) begin
                lost_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!empty) state_d = StLoad;
            StLoad:  state_d = StSend;
            StSend:  if (hs && last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        sr_d        = sr_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop  = 1'b1;
                    sr_d = mem_q[rd_ptr_q[AW-1:0]];
                end
            end
            StLoad: begin
                out_valid_d = 1'b1;
                out_data_d  = sr_q[7:0];
                idx_d       = '0;
            end
            StSend: begin
                if (hs) begin
                    if (last) begin
                        out_valid_d = 1'b0;
                    end else begin
                        sr_d       = sr_shift;
                        out_data_d = sr_shift[7:0];
                        idx_d      = idx_q + IdxW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q        <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign clear_out        = clear_q;
    assign lost             = lost_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
endmodule

// File: tb/tb_count_readout.sv
// Self-checking bench for count_readout: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of snapshots, FIFO and byte stream.
module tb_count_readout;
    localparam int unsigned Res   = 64;
    localparam int unsigned Depth = 4;
`ifdef READOUT_SEQ_EN
    localparam int unsigned Fw = Res + 8;
`else
    localparam int unsigned Fw = Res;
`endif
    localparam int unsigned Nb = Fw / 8;

    logic            clk;
    logic            reset;
    logic [Res-1:0]  counter_in;
    logic            overflow;
    logic            capture;
    logic            out_ready;
    logic            clear_out;
    logic            lost;
    logic [7:0]      out_data;
    logic            out_valid;

    count_readout_if bus ();
    assign bus.out_ready = out_ready;
    assign out_data      = bus.out_data;
    assign out_valid     = bus.out_valid;

    count_readout #(
        .RESOLUTION (Res),
        .DEPTH      (Depth)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .counter_in (counter_in),
        .overflow   (overflow),
        .capture    (capture),
        .clear_out  (clear_out),
        .lost       (lost),
        .out_if     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;
    int cnt_clear = 0;
    int cnt_hs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of pending snapshots, the frame being transmitted as a byte list,
    // and the expected registered outputs.
    logic [Fw-1:0] mq[$];
    logic [7:0]    cur[$];
    bit            m_busy = 1'b0;
    bit            m_wait = 1'b0;
    bit            m_valid = 1'b0;
    logic [7:0]    m_data = 8'h00;
    bit            m_clear = 1'b0;
    bit            m_lost = 1'b0;
    bit            m_ovq = 1'b0;
    logic [7:0]    m_seq = 8'h00;

    always @(posedge clk) begin
        int            pre_cnt;
        bit            t;
        logic [Fw-1:0] fr;
        logic [Fw-1:0] ent;
        if (!reset) begin
            mq.delete();
            cur.delete();
            m_busy  = 1'b0;
            m_wait  = 1'b0;
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_clear = 1'b0;
            m_lost  = 1'b0;
            m_ovq   = 1'b0;
            m_seq   = 8'h00;
        end else begin
            pre_cnt = mq.size();
            t = capture | (overflow & ~m_ovq);
            if (!m_busy && pre_cnt > 0) begin
                fr = mq.pop_front();
                cur.delete();
                for (int i = 0; i < Nb; i++) cur.push_back(fr[8*i +: 8]);
                m_busy = 1'b1;
                m_wait = 1'b1;
            end else if (m_wait) begin
                m_wait  = 1'b0;
                m_valid = 1'b1;
                m_data  = cur[0];
            end else if (m_valid && out_ready) begin
                void'(cur.pop_front());
                if (cur.size() == 0) begin
                    m_valid = 1'b0;
                    m_busy  = 1'b0;
                end else begin
                    m_data = cur[0];
                end
            end
            if (t) begin
`ifdef READOUT_SEQ_EN
                ent = {counter_in, m_seq};
`else
                ent = counter_in;
`endif
                if (pre_cnt < Depth) mq.push_back(ent);
                else m_lost = 1'b1;
                m_seq = m_seq + 8'd1;
            end
            m_clear = t;
            m_ovq   = overflow;
        end
    end

    always @(posedge clk) begin
        if (clear_out) cnt_clear++;
        if (reset && out_valid && out_ready) cnt_hs++;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("clear_out", clear_out, m_clear);
            check("lost", lost, m_lost);
            check("out_valid", out_valid, m_valid);
            if (m_valid) check("out_data", out_data, m_data);
        end
    end

    task automatic drain();
        int n = 0;
        while ((mq.size() != 0 || m_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", (n < 2000), 1);
        @(negedge clk);
    endtask

    logic [63:0] cval;
    int c0, h0;

    initial begin
        reset = 1'b0; capture = 1'b0; overflow = 1'b0; counter_in = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_clear", clear_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_lost", lost, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single capture: clear pulse, then bytes 01..08 starting two edges later.
        counter_in = 64'h0807060504030201;
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        check("t1_clear_hi", clear_out, 1);
        check("t1_valid_lo0", out_valid, 0);
        @(negedge clk);
        check("t1_clear_lo", clear_out, 0);
        check("t1_valid_lo1", out_valid, 0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("t1_byte", {out_valid, out_data}, {1'b1, 8'(i)});
        end
        @(negedge clk);
        check("t1_valid_end", out_valid, 0);
        drain();

        // Overflow held 10 cycles with a capture in its first cycle: one snapshot.
        c0 = cnt_clear;
        counter_in = {$urandom, $urandom};
        overflow = 1'b1;
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        repeat (9) @(negedge clk);
        overflow = 1'b0;
        drain();
        check("t2_one_clear", cnt_clear - c0, 1);

        // Stall mid-frame on the third byte.
        cval = {$urandom, $urandom};
        counter_in = cval;
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_byte3", out_data, cval[23:16]);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t3_hold", {out_valid, out_data}, {1'b1, cval[23:16]});
        end
        out_ready = 1'b1;
        drain();

        // Back-to-back captures while stalled: one frame in flight, four buffered, one dropped.
        c0 = cnt_clear;
        h0 = cnt_hs;
        out_ready = 1'b0;
        capture = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            counter_in = {$urandom, $urandom};
            @(negedge clk);
            if (k == 5) check("t4_lost_lo", lost, 0);
        end
        capture = 1'b0;
        check("t4_lost_hi", lost, 1);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        drain();
        check("t4_clears", cnt_clear - c0, 6);
        check("t4_bytes", cnt_hs - h0, 5 * Nb);
        check("t4_lost_sticky", lost, 1);

        // Reset on the third byte of a frame.
        counter_in = {$urandom, $urandom};
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_clear", clear_out, 0);
        check("t5_valid", out_valid, 0);
        check("t5_data", out_data, 0);
        check("t5_lost", lost, 0);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t5_quiet", out_valid, 0);
        end
        counter_in = {$urandom, $urandom};
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        drain();

        // Random traffic including occasional resets.
        for (int c = 0; c < 4000; c++) begin
            counter_in = {$urandom, $urandom};
            capture = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) overflow = ~overflow;
            out_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 799) != 0);
            @(negedge clk);
        end
        reset = 1'b1; capture = 1'b0; overflow = 1'b0; out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
